// File: rtl/operand_fetch_stage.sv
// ID/EX operand fetch stage, downstream of the 32x32 register file.
//
// Drives the register-file read addresses straight from the decoded instruction. It captures
// the read data and the decode fields into an ID/EX register. Valid/ready handshakes are used
// on both sides. A one-entry skid buffer keeps full throughput while in_ready depends only on
// registered state and reset.
//
// Optional feature: define OPF_FORWARD_EN to resolve same-cycle writeback hazards. The register
// file writes at posedge and reads combinationally, so a same-cycle read returns the old value.
// With forwarding enabled:
//   - the capture path selects wb_wrData on an address match;
//   - held entries snoop matching writebacks.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   flush                 drop held entries and the same-cycle accept
//   in_*                  decoded instruction with valid/ready handshake
//   rf_rdAddrA/B          register-file read addresses (= in_rs / in_rt)
//   rf_rdDataA/B          register-file read data
//   wb_RegWrite/wrAddr/wrData  writeback port, shared with the register file
//   out_*                 ID/EX entry with valid/ready handshake
//   stall_cnt             saturating count of cycles with out_valid && !out_ready
module operand_fetch_stage #(
  parameter int unsigned OPW    = 6,
  parameter int unsigned STALLW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic [OPW-1:0]    in_op,
  output logic [4:0]        rf_rdAddrA,
  output logic [4:0]        rf_rdAddrB,
  input  logic [31:0]       rf_rdDataA,
  input  logic [31:0]       rf_rdDataB,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_wrAddr,
  input  logic [31:0]       wb_wrData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_opA,
  output logic [31:0]       out_opB,
  output logic [31:0]       out_imm,
  output logic [OPW-1:0]    out_op,
  output logic [4:0]        out_rd,
  output logic [STALLW-1:0] stall_cnt
);

  logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [31:0]       out_opa_q, out_opa_d, out_opb_q, out_opb_d, out_imm_q, out_imm_d;
  logic [OPW-1:0]    out_op_q, out_op_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [31:0]       skid_opa_q, skid_opa_d, skid_opb_q, skid_opb_d, skid_imm_q, skid_imm_d;
  logic [OPW-1:0]    skid_op_q, skid_op_d;
  logic [4:0]        skid_rd_q, skid_rd_d;
  logic [STALLW-1:0] stall_cnt_q, stall_cnt_d;

  logic        accept, out_load, out_from_skid, out_from_in, skid_from_in;
  logic [31:0] cap_opa, cap_opb;
  logic [31:0] out_opa_hold, out_opb_hold, skid_opa_hold, skid_opb_hold;

  assign in_ready   = reset && !skid_valid_q;
  assign accept     = in_valid && in_ready;
  assign rf_rdAddrA = in_rs;
  assign rf_rdAddrB = in_rt;

  // Skid is always older than a new accept, so it has first claim on the output register.
  assign out_load      = !out_valid_q || out_ready;
  assign out_from_skid = out_load && skid_valid_q;
  assign out_from_in   = out_load && !skid_valid_q && accept;
  assign skid_from_in  = accept && (skid_valid_q || !out_load);

`ifdef OPF_FORWARD_EN
  logic [4:0] out_rs_q, out_rs_d, out_rt_q, out_rt_d;
  logic [4:0] skid_rs_q, skid_rs_d, skid_rt_q, skid_rt_d;

  assign cap_opa = (wb_RegWrite && wb_wrAddr == in_rs) ? wb_wrData : rf_rdDataA;
  assign cap_opb = (wb_RegWrite && wb_wrAddr == in_rt) ? wb_wrData : rf_rdDataB;

  // Held operands snoop the writeback so they never go stale while waiting.
  assign out_opa_hold  = (wb_RegWrite && wb_wrAddr == out_rs_q)  ? wb_wrData : out_opa_q;
  assign out_opb_hold  = (wb_RegWrite && wb_wrAddr == out_rt_q)  ? wb_wrData : out_opb_q;
  assign skid_opa_hold = (wb_RegWrite && wb_wrAddr == skid_rs_q) ? wb_wrData : skid_opa_q;
  assign skid_opb_hold = (wb_RegWrite && wb_wrAddr == skid_rt_q) ? wb_wrData : skid_opb_q;

  always_comb begin
    out_rs_d  = out_rs_q;
    out_rt_d  = out_rt_q;
    skid_rs_d = skid_rs_q;
    skid_rt_d = skid_rt_q;
    if (out_from_skid) begin
      out_rs_d = skid_rs_q;
      out_rt_d = skid_rt_q;
    end else if (out_from_in) begin
      out_rs_d = in_rs;
      out_rt_d = in_rt;
    end
    if (skid_from_in) begin
      skid_rs_d = in_rs;
      skid_rt_d = in_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_rs_q  <= '0;
      out_rt_q  <= '0;
      skid_rs_q <= '0;
      skid_rt_q <= '0;
    end else begin
      out_rs_q  <= out_rs_d;
      out_rt_q  <= out_rt_d;
      skid_rs_q <= skid_rs_d;
      skid_rt_q <= skid_rt_d;
    end
  end
`else
  assign cap_opa       = rf_rdDataA;
  assign cap_opb       = rf_rdDataB;
  assign out_opa_hold  = out_opa_q;
  assign out_opb_hold  = out_opb_q;
  assign skid_opa_hold = skid_opa_q;
  assign skid_opb_hold = skid_opb_q;

  // Writeback is only needed for forwarding; hazards are left to the upstream interlock.
  logic unused_wb;
  assign unused_wb = ^{wb_RegWrite, wb_wrAddr, wb_wrData};
`endif

  always_comb begin
    out_valid_d  = !flush && (out_load ? (skid_valid_q || accept) : 1'b1);
    skid_valid_d = !flush && (skid_from_in || (skid_valid_q && !out_load));

    out_opa_d  = out_opa_hold;
    out_opb_d  = out_opb_hold;
    out_imm_d  = out_imm_q;
    out_op_d   = out_op_q;
    out_rd_d   = out_rd_q;
    skid_opa_d = skid_opa_hold;
    skid_opb_d = skid_opb_hold;
    skid_imm_d = skid_imm_q;
    skid_op_d  = skid_op_q;
    skid_rd_d  = skid_rd_q;

    if (out_from_skid) begin
      out_opa_d = skid_opa_hold;
      out_opb_d = skid_opb_hold;
      out_imm_d = skid_imm_q;
      out_op_d  = skid_op_q;
      out_rd_d  = skid_rd_q;
    end else if (out_from_in) begin
      out_opa_d = cap_opa;
      out_opb_d = cap_opb;
      out_imm_d = in_imm;
      out_op_d  = in_op;
      out_rd_d  = in_rd;
    end
    if (skid_from_in) begin
      skid_opa_d = cap_opa;
      skid_opb_d = cap_opb;
      skid_imm_d = in_imm;
      skid_op_d  = in_op;
      skid_rd_d  = in_rd;
    end

    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALLW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_opa_q    <= '0;
      out_opb_q    <= '0;
      out_imm_q    <= '0;
      out_op_q     <= '0;
      out_rd_q     <= '0;
      skid_opa_q   <= '0;
      skid_opb_q   <= '0;
      skid_imm_q   <= '0;
      skid_op_q    <= '0;
      skid_rd_q    <= '0;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_opa_q    <= out_opa_d;
      out_opb_q    <= out_opb_d;
      out_imm_q    <= out_imm_d;
      out_op_q     <= out_op_d;
      out_rd_q     <= out_rd_d;
      skid_opa_q   <= skid_opa_d;
      skid_opb_q   <= skid_opb_d;
      skid_imm_q   <= skid_imm_d;
      skid_op_q    <= skid_op_d;
      skid_rd_q    <= skid_rd_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_opA   = out_opa_q;
  assign out_opB   = out_opb_q;
  assign out_imm   = out_imm_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  localparam int unsigned OPW    = 6;
  localparam int unsigned STALLW = 4;
  localparam int unsigned MAXST  = 15;
`ifdef OPF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk, reset, flush, in_valid, in_ready;
  logic [4:0]        in_rs, in_rt, in_rd, rf_rdAddrA, rf_rdAddrB, wb_wrAddr, out_rd;
  logic [31:0]       in_imm, rf_rdDataA, rf_rdDataB, wb_wrData, out_opA, out_opB, out_imm;
  logic [OPW-1:0]    in_op, out_op;
  logic              wb_RegWrite, out_valid, out_ready;
  logic [STALLW-1:0] stall_cnt;

  operand_fetch_stage #(.OPW(OPW), .STALLW(STALLW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm(in_imm), .in_op(in_op),
    .rf_rdAddrA(rf_rdAddrA), .rf_rdAddrB(rf_rdAddrB),
    .rf_rdDataA(rf_rdDataA), .rf_rdDataB(rf_rdDataB),
    .wb_RegWrite(wb_RegWrite), .wb_wrAddr(wb_wrAddr), .wb_wrData(wb_wrData),
    .out_valid(out_valid), .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
    .out_imm(out_imm), .out_op(out_op), .out_rd(out_rd), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: posedge write, combinational read.
  logic [31:0] rf [32];
  assign rf_rdDataA = rf[rf_rdAddrA];
  assign rf_rdDataB = rf[rf_rdAddrB];

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Behavioural model: an ordered queue of at most two in-flight instructions.
  typedef struct {
    logic [4:0]     rs, rt, rd;
    logic [31:0]    a, b, imm;
    logic [OPW-1:0] op;
  } ent_t;
  ent_t mq[$];
  int   m_stall = 0;

  always @(posedge clk) begin
    ent_t e;
    logic acc;
    acc = in_valid && reset && (mq.size() < 2);
    if (!reset) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall != MAXST) m_stall++;
      if (FWD && wb_RegWrite) begin
        foreach (mq[i]) begin
          if (mq[i].rs == wb_wrAddr) mq[i].a = wb_wrData;
          if (mq[i].rt == wb_wrAddr) mq[i].b = wb_wrData;
        end
      end
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        e.rs = in_rs; e.rt = in_rt; e.rd = in_rd; e.imm = in_imm; e.op = in_op;
        e.a = (FWD && wb_RegWrite && wb_wrAddr == in_rs) ? wb_wrData : rf[in_rs];
        e.b = (FWD && wb_RegWrite && wb_wrAddr == in_rt) ? wb_wrData : rf[in_rt];
        mq.push_back(e);
      end
      if (flush) mq.delete();
    end
    if (wb_RegWrite) rf[wb_wrAddr] <= wb_wrData;
  end

  // Compare process: every negedge, DUT against the model.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(reset && mq.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("rd_addr", 64'({rf_rdAddrA, rf_rdAddrB}), 64'({in_rs, in_rt}));
    if (mq.size() > 0) begin
      chk("out_opA", 64'(out_opA), 64'(mq[0].a));
      chk("out_opB", 64'(out_opB), 64'(mq[0].b));
      chk("out_imm", 64'(out_imm), 64'(mq[0].imm));
      chk("out_op_rd", 64'({out_op, out_rd}), 64'({mq[0].op, mq[0].rd}));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    in_valid = 1'b1;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rs ^ rt;
    in_imm   = imm;
    in_op    = imm[5:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_RegWrite = en;
    wb_wrAddr   = addr;
    wb_wrData   = data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_op = '0;
    wb(1'b0, 5'd0, 32'h0);

    // 1: reset for two cycles, then release.
    cyc(); cyc();
    chk("lit_rst_valid", 64'(out_valid), 64'd0);
    chk("lit_rst_opA", 64'({out_opA, out_imm}), 64'd0);
    reset = 1'b1;
    #1;
    chk("lit_rel_ready", 64'(in_ready), 64'd1);
    chk("lit_rel_stall", 64'(stall_cnt), 64'd0);

    // 2: basic capture and back-to-back throughput.
    instr(5'd3, 5'd4, 32'hFFFF_FFF0);
    cyc();
    chk("lit_t2_opA", 64'(out_opA), 64'h11);
    chk("lit_t2_opB", 64'(out_opB), 64'h22);
    chk("lit_t2_imm", 64'(out_imm), 64'hFFFF_FFF0);
    instr(5'd4, 5'd3, 32'h2);
    cyc();
    chk("lit_t2b_opA", 64'({out_valid, out_opA}), 64'h1_0000_0022);
    instr(5'd0, 5'd0, 32'h3);
    cyc();
    chk("lit_t2c_opA", 64'({out_valid, out_opA}), 64'h1_0000_0000);
    idle();
    cyc();

    // 3: backpressure fills the skid, then drains in order.
    out_ready = 1'b0;
    instr(5'd3, 5'd4, 32'h31);
    cyc();
    instr(5'd4, 5'd3, 32'h32);
    cyc();
    chk("lit_t3_ready", 64'(in_ready), 64'd0);
    chk("lit_t3_stall1", 64'(stall_cnt), 64'd1);
    idle();
    cyc(); cyc();
    chk("lit_t3_stall3", 64'(stall_cnt), 64'd3);
    chk("lit_t3_I1", 64'(out_opA), 64'h11);
    out_ready = 1'b1;
    cyc();
    chk("lit_t3_I2", 64'({out_valid, out_opA, out_imm}), {31'd0, 1'b1, 32'h22, 32'h32} >> 0);
    chk("lit_t3_ready1", 64'(in_ready), 64'd1);
    cyc();

    // 4: same-cycle writeback hazard on capture.
    instr(5'd5, 5'd0, 32'h4);
    wb(1'b1, 5'd5, 32'hDEAD);
    cyc();
    chk("lit_t4_opA", 64'(out_opA), FWD ? 64'hDEAD : 64'h0);
    wb(1'b0, 5'd0, 32'h0);
    idle();
    cyc();

    // 5: writeback snoop on the output register.
    out_ready = 1'b0;
    instr(5'd0, 5'd7, 32'h5);
    cyc();
    chk("lit_t5_opB0", 64'(out_opB), 64'h0);
    idle();
    wb(1'b1, 5'd7, 32'h77);
    cyc();
    chk("lit_t5_opB", 64'(out_opB), FWD ? 64'h77 : 64'h0);
    wb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    cyc();

    // Snoop on the skid entry, observed once it reaches the output.
    out_ready = 1'b0;
    instr(5'd3, 5'd4, 32'hA);
    cyc();
    instr(5'd4, 5'd7, 32'hB);
    cyc();
    idle();
    wb(1'b1, 5'd4, 32'h44);
    cyc();
    wb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    cyc();
    chk("lit_skid_opA", 64'(out_opA), FWD ? 64'h44 : 64'h22);
    chk("lit_skid_opB", 64'(out_opB), 64'h77);
    cyc();

    // 6: flush with output and skid both full.
    out_ready = 1'b0;
    instr(5'd3, 5'd3, 32'hC1);
    cyc();
    instr(5'd3, 5'd3, 32'hC2);
    cyc();
    instr(5'd5, 5'd5, 32'hBAD);
    flush = 1'b1;
    cyc();
    chk("lit_t6_valid", 64'(out_valid), 64'd0);
    chk("lit_t6_ready", 64'(in_ready), 64'd1);
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    cyc(); cyc();
    chk("lit_t6_gone", 64'(out_valid), 64'd0);

    // Flush drops a same-cycle accept.
    out_ready = 1'b0;
    instr(5'd3, 5'd4, 32'hD1);
    cyc();
    instr(5'd3, 5'd4, 32'hBAD2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    idle();
    chk("lit_fl2_valid", 64'(out_valid), 64'd0);
    cyc();
    chk("lit_fl2_gone", 64'(out_valid), 64'd0);

    // stall_cnt saturates and survives flush.
    instr(5'd1, 5'd2, 32'h5A);
    cyc();
    idle();
    repeat (20) cyc();
    chk("lit_sat", 64'(stall_cnt), 64'(MAXST));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("lit_sat_flush", 64'(stall_cnt), 64'(MAXST));

    // Reset mid-operation discards held entries.
    instr(5'd3, 5'd4, 32'hE1);
    cyc();
    instr(5'd4, 5'd3, 32'hE2);
    cyc();
    idle();
    reset = 1'b0;
    cyc();
    chk("lit_mr_valid", 64'({in_ready, out_valid}), 64'd0);
    chk("lit_mr_data", 64'({out_opA, out_imm}), 64'd0);
    chk("lit_mr_oprd", 64'({out_op, out_rd, stall_cnt}), 64'd0);
    reset = 1'b1;
    #1;
    chk("lit_mr_ready", 64'(in_ready), 64'd1);

    // Mixed traffic: varying backpressure with writebacks and one flush.
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 != 0);
      instr(5'(i % 8), 5'((i + 3) % 8), 32'(i));
      wb(i % 2 == 1, 5'(i % 8), 32'h1000 + 32'(i));
      flush = (i == 25);
      cyc();
    end
    flush = 1'b0;
    idle();
    wb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("lit_end_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
